// File: rtl/lsu.sv
// Load/store unit between execute and the 64-bit synchronous data SRAM.
// One request at a time: IDLE -> ACCESS -> (WAIT) -> RESP, or IDLE -> RESP on a bad request.
module lsu #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [7:0]        mem_be,
    output logic [ADDR_W-4:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // the sender holds valid and its payload stable until that edge.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        accept;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [2:0]  off_q;

    logic        req_illegal;
    logic [7:0]  req_be;
    logic [63:0] req_wrep;
    logic [63:0] rd_shift;
    logic [63:0] load_ext;

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign dbg_state  = state_q;

    always_comb begin
        req_illegal = 1'b0;
        if (req_funct3 == 3'b111) begin
            req_illegal = 1'b1;
        end else if (req_we && req_funct3[2]) begin
            req_illegal = 1'b1;
        end else begin
            case (req_funct3[1:0])
                2'd1:    req_illegal = req_addr[0];
                2'd2:    req_illegal = |req_addr[1:0];
                2'd3:    req_illegal = |req_addr[2:0];
                default: req_illegal = 1'b0;
            endcase
        end
    end

    // Lane mask and replicated data by access size; the shift never overflows on legal requests.
    always_comb begin
        case (req_funct3[1:0])
            2'd0: begin
                req_be   = 8'h01 << req_addr[2:0];
                req_wrep = {8{req_wdata[7:0]}};
            end
            2'd1: begin
                req_be   = 8'h03 << req_addr[2:0];
                req_wrep = {4{req_wdata[15:0]}};
            end
            2'd2: begin
                req_be   = 8'h0F << req_addr[2:0];
                req_wrep = {2{req_wdata[31:0]}};
            end
            default: begin
                req_be   = 8'hFF;
                req_wrep = req_wdata;
            end
        endcase
    end

    assign rd_shift = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (f3_q)
            3'b000:  load_ext = {{56{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_ext = {{48{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  load_ext = {{32{rd_shift[31]}}, rd_shift[31:0]};
            3'b011:  load_ext = rd_shift;
            3'b100:  load_ext = {56'b0, rd_shift[7:0]};
            3'b101:  load_ext = {48'b0, rd_shift[15:0]};
            3'b110:  load_ext = {32'b0, rd_shift[31:0]};
            default: load_ext = 64'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = req_illegal ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: state_d = we_q ? S_RESP : S_WAIT;
            S_WAIT:   state_d = S_RESP;
            S_RESP:   if (resp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // mem_en/we/be/wdata pulse for exactly the ACCESS cycle and rest at zero otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_q       <= 1'b0;
            f3_q       <= 3'b0;
            off_q      <= 3'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= 8'b0;
            mem_addr   <= '0;
            mem_wdata  <= 64'b0;
            resp_rdata <= 64'b0;
            resp_err   <= 1'b0;
        end else begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 8'b0;
            mem_wdata <= 64'b0;
            if (accept) begin
                we_q       <= req_we;
                f3_q       <= req_funct3;
                off_q      <= req_addr[2:0];
                resp_rdata <= 64'b0;
                resp_err   <= req_illegal;
                if (!req_illegal) begin
                    mem_en    <= 1'b1;
                    mem_we    <= req_we;
                    mem_be    <= req_be;
                    mem_addr  <= req_addr[ADDR_W-1:3];
                    mem_wdata <= req_we ? req_wrep : 64'b0;
                end
            end
            if (state_q == S_WAIT) resp_rdata <= load_ext;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a behavioural 64-bit SRAM, one request driver, hand-computed expectations.
`timescale 1ns/1ps
module tb_lsu;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_be;
    logic [8:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] sram [0:511];

    lsu #(.ADDR_W(12)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // synchronous SRAM with byte enables
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 8; b++)
                    if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // strobe-qualified outputs must be quiet outside the ACCESS pulse
    always @(negedge clk) begin
        if (rstn && !mem_en)
            check("mem_quiet", {63'b0, (mem_we | (|mem_be) | (|mem_wdata))}, 64'd0);
    end

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [11:0] addr,
                          input logic [63:0] wdata, input int exp_lat, input logic [63:0] exp_rdata,
                          input logic exp_err, input logic [7:0] exp_be, input logic [63:0] exp_mwdata,
                          input int hold);
        int          lat;
        int          n_en;
        int          w;
        logic [7:0]  c_be;
        logic [63:0] c_wd;
        logic [8:0]  c_addr;
        logic        c_we;
        c_be = 0; c_wd = 0; c_addr = 0; c_we = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = (hold == 0);
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("req_ready_idle", {63'b0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = 12'($urandom_range(0, 4095));
        req_wdata  = {$urandom, $urandom};
        lat  = 0;
        n_en = 0;
        do begin
            @(negedge clk);
            lat++;
            if (mem_en) begin
                n_en++;
                c_be = mem_be; c_wd = mem_wdata; c_addr = mem_addr; c_we = mem_we;
            end
        end while (!resp_valid && lat < 10);
        check("resp_latency", 64'(lat), 64'(exp_lat));
        if (!resp_valid) begin
            resp_ready = 1'b1;
            return;
        end
        check("resp_rdata", resp_rdata, exp_rdata);
        check("resp_err", {63'b0, resp_err}, {63'b0, exp_err});
        check("no_overlap", {63'b0, req_ready}, 64'd0);
        check("mem_en_count", 64'(n_en), exp_err ? 64'd0 : 64'd1);
        if (!exp_err) begin
            check("mem_be", {56'b0, c_be}, {56'b0, exp_be});
            check("mem_addr", {55'b0, c_addr}, {55'b0, addr[11:3]});
            check("mem_we", {63'b0, c_we}, {63'b0, we});
            if (we) check("mem_wdata", c_wd, exp_mwdata);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", {63'b0, resp_valid}, 64'd1);
            check("hold_rdata", resp_rdata, exp_rdata);
            check("hold_ready", {63'b0, req_ready}, 64'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("resp_dropped", {63'b0, resp_valid}, 64'd0);
        check("ready_back", {63'b0, req_ready}, 64'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, {63'b0, req_ready}, 64'd1);
        check({tag, "_resp_valid"}, {63'b0, resp_valid}, 64'd0);
        check({tag, "_resp_rdata"}, resp_rdata, 64'd0);
        check({tag, "_resp_err"}, {63'b0, resp_err}, 64'd0);
        check({tag, "_mem_en"}, {63'b0, mem_en}, 64'd0);
        check({tag, "_mem_we"}, {63'b0, mem_we}, 64'd0);
        check({tag, "_mem_be"}, {56'b0, mem_be}, 64'd0);
        check({tag, "_mem_addr"}, {55'b0, mem_addr}, 64'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 64'd0);
        check({tag, "_state"}, {62'b0, dbg_state}, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) sram[i] = 64'd0;
        mem_rdata  = 64'd0;
        rstn       = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 12'd0;
        req_wdata  = 64'd0;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rstn = 1'b1;
        @(negedge clk);

        // double store/load
        do_req(1'b1, 3'b011, 12'h010, 64'h0123456789ABCDEF, 2, 64'd0, 1'b0, 8'hFF, 64'h0123456789ABCDEF, 0);
        do_req(1'b0, 3'b011, 12'h010, 64'd0, 3, 64'h0123456789ABCDEF, 1'b0, 8'hFF, 64'd0, 0);
        // byte store into lane 3, then signed/unsigned reads
        do_req(1'b1, 3'b000, 12'h013, 64'hAAAAAAAAAAAAAA80, 2, 64'd0, 1'b0, 8'h08, 64'h8080808080808080, 0);
        do_req(1'b0, 3'b000, 12'h013, 64'd0, 3, 64'hFFFFFFFFFFFFFF80, 1'b0, 8'h08, 64'd0, 0);
        do_req(1'b0, 3'b100, 12'h013, 64'd0, 3, 64'h0000000000000080, 1'b0, 8'h08, 64'd0, 0);
        // halves from the modified word 0x0123456780ABCDEF
        do_req(1'b0, 3'b001, 12'h012, 64'd0, 3, 64'hFFFFFFFFFFFF80AB, 1'b0, 8'h0C, 64'd0, 0);
        do_req(1'b0, 3'b101, 12'h016, 64'd0, 3, 64'h0000000000000123, 1'b0, 8'hC0, 64'd0, 0);
        // upper word store and reads
        do_req(1'b1, 3'b010, 12'h01C, 64'h55555555DEADBEEF, 2, 64'd0, 1'b0, 8'hF0, 64'hDEADBEEFDEADBEEF, 0);
        do_req(1'b0, 3'b010, 12'h01C, 64'd0, 3, 64'hFFFFFFFFDEADBEEF, 1'b0, 8'hF0, 64'd0, 0);
        do_req(1'b0, 3'b110, 12'h01C, 64'd0, 3, 64'h00000000DEADBEEF, 1'b0, 8'hF0, 64'd0, 0);
        // illegal requests
        do_req(1'b0, 3'b010, 12'h002, 64'd0, 1, 64'd0, 1'b1, 8'h00, 64'd0, 0);
        do_req(1'b0, 3'b001, 12'h001, 64'd0, 1, 64'd0, 1'b1, 8'h00, 64'd0, 0);
        do_req(1'b1, 3'b110, 12'h000, 64'hFFFFFFFFFFFFFFFF, 1, 64'd0, 1'b1, 8'h00, 64'd0, 0);
        do_req(1'b0, 3'b111, 12'h000, 64'd0, 1, 64'd0, 1'b1, 8'h00, 64'd0, 0);
        do_req(1'b1, 3'b011, 12'h014, 64'h1234, 1, 64'd0, 1'b1, 8'h00, 64'd0, 0);
        // illegal store must not have touched the double at word 2
        do_req(1'b0, 3'b011, 12'h010, 64'd0, 3, 64'h0123456780ABCDEF, 1'b0, 8'hFF, 64'd0, 5);

        // reset during WAIT of a load
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b011;
        req_addr   = 12'h010;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_access_en", {63'b0, mem_en}, 64'd1);
        @(negedge clk);
        check("rst_wait_state", {62'b0, dbg_state}, 64'd2);
        rstn = 1'b0;
        #1;
        check_reset_values("midrst");
        repeat (2) begin
            @(negedge clk);
            check("midrst_no_resp", {63'b0, resp_valid}, 64'd0);
        end
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_no_resp", {63'b0, resp_valid}, 64'd0);
        do_req(1'b1, 3'b011, 12'h008, 64'h1122334455667788, 2, 64'd0, 1'b0, 8'hFF, 64'h1122334455667788, 0);
        do_req(1'b0, 3'b011, 12'h008, 64'd0, 3, 64'h1122334455667788, 1'b0, 8'hFF, 64'd0, 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the core's execute stage and the 64-bit synchronous data SRAM. It accepts one memory request at a time over a valid/ready handshake and checks alignment. For stores it generates byte-lane enables and replicated write data; for loads it extracts the addressed lane and sign- or zero-extends it. It returns a registered response with an error flag, and the core stalls on the handshake.

## Interface
- ADDR_W, 12, byte address width; SRAM word address width is ADDR_W-3
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV64 size/sign: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu
- req_addr  in  ADDR_W  byte address
- req_wdata  in  64  store data, right-aligned
- resp_valid  out  1  response present; held until resp_ready
- resp_ready  in  1  consumer takes response
- resp_rdata  out  64  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal request; no SRAM access made
- mem_en  out  1  SRAM access strobe, exactly one cycle per legal request
- mem_we  out  1  SRAM write
- mem_be  out  8  byte enables; bit i = bits [8i+7:8i]
- mem_addr  out  ADDR_W-3  SRAM word address, req_addr[ADDR_W-1:3]
- mem_wdata  out  64  lane-replicated store data
- mem_rdata  in  64  read data, valid the cycle after mem_en with mem_we=0

## Operation
- States: IDLE, ACCESS, WAIT, RESP. Reset enters IDLE.
- IDLE: req_ready=1. On req_valid, register we/funct3/addr/wdata and classify the request.
  - Illegal: funct3=111; store with funct3[2]=1; half access with addr[0]!=0; word access with addr[1:0]!=0; double access with addr[2:0]!=0. Go to RESP with resp_err=1 and resp_rdata=0. mem_en is never asserted.
  - Legal: go to ACCESS.
- ACCESS: mem_en=1 with mem_we=req_we, mem_addr, mem_be and mem_wdata for one cycle. All mem_* outputs are registered.
  - mem_be for size s bytes (1/2/4/8) is ((1<<s)-1) << addr[2:0].
  - mem_wdata replicates the low s bytes of req_wdata across all lanes: byte repeated 8x, half 4x, word 2x, double as-is.
  - Next state: store goes to RESP; load goes to WAIT.
- WAIT: capture mem_rdata >> (8*addr[2:0]). Keep the low s bytes. Sign-extend if funct3[2]=0, zero-extend if funct3[2]=1; double passes through. Go to RESP.
- RESP: resp_valid=1, with resp_rdata/resp_err stable. When resp_ready=1, clear resp_valid and go to IDLE.
- Little-endian byte order throughout.
- mem_be, mem_we and mem_wdata are 0 whenever mem_en=0.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
- The request is accepted on edge 0 with req_valid & req_ready. resp_valid first rises at:
  - edge 3 for a legal load (ACCESS edge 1, WAIT edge 2)
  - edge 2 for a legal store
  - edge 1 for an error
- With resp_ready held high, resp_valid stays up 1 cycle. req_ready returns the cycle after the response handshake, so there is no request/response overlap. Minimum spacing: 4 cycles per load, 3 per store.
- Request inputs are ignored outside IDLE. The producer holds them until req_ready=1.
- Reset asserted mid-operation returns to IDLE immediately and drops any pending response.
  - A store whose ACCESS cycle already passed remains written in SRAM.
  - mem_en deasserts asynchronously.

## Test plan
- Store double 0x0123456789ABCDEF at 0x010, then load double at 0x010: mem_be=0xFF, mem_addr=0x002, resp_rdata=0x0123456789ABCDEF, resp_err=0, with resp_valid 3 cycles after acceptance.
- Store byte 0x80 at 0x013, then load byte and load byte-unsigned at 0x013:
  - store: mem_be=0x08, mem_wdata=0x8080808080808080
  - lb returns 0xFFFFFFFFFFFFFF80; lbu returns 0x0000000000000080.
- Store word 0xDEADBEEF at 0x01C, then load word and load word-unsigned at 0x01C:
  - store: mem_be=0xF0
  - lw returns 0xFFFFFFFFDEADBEEF; lwu returns 0x00000000DEADBEEF.
- Misaligned load word at 0x002, load half at 0x001, store with funct3=110, and request with funct3=111: each gives resp_err=1 and resp_rdata=0 one cycle after acceptance. mem_en is never asserted.
- Load with resp_ready held low for 5 cycles after resp_valid: resp_valid and resp_rdata stay stable and req_ready stays 0. The handshake completes when resp_ready rises, and req_ready=1 on the next cycle.
- Assert rstn low during WAIT of a load: all outputs take reset values immediately, no response is issued, and a following store/load pair at 0x008 completes normally.
